dmac_apb_slave: RTL and testbench
=================================

# dmac_apb_slave

APB3 slave front-end for the DMA controller's configuration space. It sits directly upstream of the DMAC configuration registers. It converts APB setup/access transactions into registered reads and writes of the source, destination, length, command and status registers, and drives the DMA engine's start pulse. Every transfer adds exactly one wait state, so read data and error responses are fully registered.

## Interface
Parameters:
- VERSION, 32'h0001_2024, value returned by the VERSION register.

Ports:
- Clock and reset: single clock `clk`; reset `rst_n` is asynchronous, active-low.
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- psel_i  input  1  APB select.
- penable_i  input  1  APB enable (access phase).
- paddr_i  input  12  APB byte address; bits [1:0] ignored.
- pwrite_i  input  1  1 = write, 0 = read.
- pwdata_i  input  32  APB write data.
- pready_o  output  1  transfer completes this cycle.
- prdata_o  output  32  read data; valid when pready_o=1.
- pslverr_o  output  1  error response; valid when pready_o=1.
- src_addr_o  output  32  DMA source address.
- dst_addr_o  output  32  DMA destination address.
- byte_len_o  output  16  DMA length in bytes.
- start_o  output  1  one-cycle start pulse to the engine.
- done_i  input  1  one-cycle completion pulse from the engine.

## Operation
Register map:
- 0x000 VERSION, RO, returns VERSION.
- 0x100 SRC_ADDR, RW, 32 bits.
- 0x104 DST_ADDR, RW, 32 bits.
- 0x108 BYTE_LEN, RW, bits [15:0]; upper bits read 0 and are ignored on write.
- 0x10C CMD, WO, reads 0.
  - bit0 = start: accepted only when not busy.
  - bit1 = clear done flag.
  - Both bits may be set in one write.
- 0x110 STATUS, RO.
  - bit0 = busy.
  - bit1 = done flag (sticky).
  - Other bits read 0.

Error rules (pslverr_o=1, no register changes):
- Any unmapped address: read data 0.
- Write to a RO register.
- Write to SRC_ADDR, DST_ADDR or BYTE_LEN while busy.
- Write to CMD with bit0=1 while busy. The whole write is rejected, bit1 included.
- CMD with bit0=0 and bit1=1 is always accepted.

Engine-side behaviour:
- An accepted start sets busy=1 and pulses start_o for exactly one cycle.
- done_i while busy clears busy and sets the done flag.
- done_i while not busy is ignored.

## Timing
FSM states: IDLE, WAIT, RESP.
- IDLE to WAIT: on psel_i=1 and penable_i=0. Capture paddr_i, pwrite_i and pwdata_i.
- WAIT: decode the captured address and sample busy. Register prdata and pslverr and the accept decision. Go to RESP.
- RESP: pready_o=1 (registered; equivalent to state==RESP).
  - On this edge, commit an accepted write.
  - start_o is high in the cycle after RESP.
  - Return to IDLE.
- A transfer therefore takes one setup cycle plus two access cycles.
- If psel_i falls in WAIT or RESP (protocol violation): return to IDLE with no commit; pready_o is 0 in the next cycle.
- Simultaneous events:
  - done_i in the same cycle as a start commit: busy ends 1 and the done flag ends 1; start wins over done.
  - done_i in the same cycle as a CMD bit1 clear: the done flag ends 1; set wins over clear.
- Busy is sampled in WAIT. A done_i arriving in RESP does not change an already-made reject decision.
- Reset values: pready_o=0, prdata_o=0, pslverr_o=0, src_addr_o=0, dst_addr_o=0, byte_len_o=0, start_o=0. Also busy=0, done flag=0, FSM=IDLE.
- Reset asserted mid-transfer aborts it immediately and commits nothing.

## Structure
- Shared package `dmac_pkg` holds:
  - register offset localparams (VERSION, SRC_ADDR, DST_ADDR, BYTE_LEN, CMD, STATUS);
  - the CMD and STATUS bit-index constants;
  - the FSM state enum `apb_state_t`.
- Single module, no sub-modules. The APB FSM, decode and register file fit comfortably in one block.

## Test plan
- Reset, then read 0x000: pready_o high on the third cycle of the transfer, prdata_o=32'h0001_2024, pslverr_o=0.
- Write SRC_ADDR=0x1000_0000, DST_ADDR=0x2000_0000, BYTE_LEN=0x0000_0040, then read each back:
  - outputs match;
  - BYTE_LEN reads 0x40;
  - writing 0xFFFF_0080 to BYTE_LEN reads back 0x80.
- Write CMD=1:
  - start_o pulses exactly one cycle after RESP;
  - STATUS reads 0x1;
  - a further write to SRC_ADDR returns pslverr_o=1 and the value is unchanged.
- Pulse done_i: STATUS reads 0x2. Write CMD=2: STATUS reads 0x0. done_i while idle leaves STATUS at 0x0.
- Read 0x200 gives prdata_o=0 and pslverr_o=1. Write to 0x110 gives pslverr_o=1.
- Drop psel_i during WAIT of a SRC_ADDR write: no commit and no pready_o. Assert rst_n=0 during RESP of a CMD=1 write: start_o stays 0 and busy=0.

Source files
------------

// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC configuration space: register offsets,
// CMD/STATUS bit positions and the APB slave state encoding.
package dmac_pkg;

    localparam logic [11:0] REG_VERSION  = 12'h000;
    localparam logic [11:0] REG_SRC_ADDR = 12'h100;
    localparam logic [11:0] REG_DST_ADDR = 12'h104;
    localparam logic [11:0] REG_BYTE_LEN = 12'h108;
    localparam logic [11:0] REG_CMD      = 12'h10C;
    localparam logic [11:0] REG_STATUS   = 12'h110;

    localparam int CMD_START_BIT   = 0;
    localparam int CMD_CLEAR_BIT   = 1;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_DONE_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_t;

endpackage

// File: rtl/dmac_apb_slave_if.sv
// APB3 bus bundle between the system interconnect and the DMAC config slave.
interface dmac_apb_slave_if;

    logic        psel_i;
    logic        penable_i;
    logic [11:0] paddr_i;
    logic        pwrite_i;
    logic [31:0] pwdata_i;
    logic        pready_o;
    logic [31:0] prdata_o;
    logic        pslverr_o;

    modport slave (
        input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        output pready_o, prdata_o, pslverr_o
    );

    modport master (
        output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
        input  pready_o, prdata_o, pslverr_o
    );

endinterface

// File: rtl/dmac_apb_slave.sv
// APB3 slave for the DMAC configuration registers. Every transfer takes one
// wait state: the address is decoded in WAIT and the response is presented
// fully registered in RESP, where an accepted write is committed.
module dmac_apb_slave
    import dmac_pkg::*;
#(
    parameter logic [31:0] VERSION = 32'h0001_2024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmac_apb_slave_if.slave        apb,
    output logic [31:0]            src_addr_o,
    output logic [31:0]            dst_addr_o,
    output logic [15:0]            byte_len_o,
    output logic                   start_o,
    input  logic                   done_i
);

    apb_state_t  r_state;
    logic [9:0]  r_word;
    logic        r_write;
    logic [31:0] r_wdata;
    logic        r_accept;
    logic        r_pready;
    logic [31:0] r_prdata;
    logic        r_pslverr;

    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [15:0] r_len;
    logic        r_start;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_rdata;
    logic        w_err;
    logic        w_accept;
    logic        w_commit;
    logic        w_cmdCommit;
    logic        w_startCommit;
    logic        w_clearCommit;
    logic        w_doneSet;

    // Decode the captured word address into read data, error and accept flags.
    always_comb begin
        w_rdata  = '0;
        w_err    = 1'b0;
        w_accept = 1'b0;
        case (r_word)
            REG_VERSION[11:2]: begin
                w_err = r_write;
                if (!r_write) w_rdata = VERSION;
            end
            REG_SRC_ADDR[11:2]: begin
                if (r_write) begin
                    w_err    = r_busy;
                    w_accept = !r_busy;
                end else begin
                    w_rdata = r_src;
                end
            end
            REG_DST_ADDR[11:2]: begin
                if (r_write) begin
                    w_err    = r_busy;
                    w_accept = !r_busy;
                end else begin
                    w_rdata = r_dst;
                end
            end
            REG_BYTE_LEN[11:2]: begin
                if (r_write) begin
                    w_err    = r_busy;
                    w_accept = !r_busy;
                end else begin
                    w_rdata = {16'h0000, r_len};
                end
            end
            REG_CMD[11:2]: begin
                if (r_write) begin
                    w_err    = r_wdata[CMD_START_BIT] && r_busy;
                    w_accept = !(r_wdata[CMD_START_BIT] && r_busy);
                end
            end
            REG_STATUS[11:2]: begin
                w_err = r_write;
                if (!r_write) begin
                    w_rdata[STATUS_BUSY_BIT] = r_busy;
                    w_rdata[STATUS_DONE_BIT] = r_done;
                end
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    assign w_commit      = (r_state == RESP) && apb.psel_i && r_accept;
    assign w_cmdCommit   = w_commit && (r_word == REG_CMD[11:2]);
    assign w_startCommit = w_cmdCommit && r_wdata[CMD_START_BIT];
    assign w_clearCommit = w_cmdCommit && r_wdata[CMD_CLEAR_BIT];
    assign w_doneSet     = done_i && (r_busy || w_startCommit);

    // APB transfer FSM with registered pready/prdata/pslverr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_word    <= '0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_accept  <= 1'b0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pready <= 1'b0;
                    r_accept <= 1'b0;
                    if (apb.psel_i && !apb.penable_i) begin
                        r_word  <= apb.paddr_i[11:2];
                        r_write <= apb.pwrite_i;
                        r_wdata <= apb.pwdata_i;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!apb.psel_i) begin
                        r_pready <= 1'b0;
                        r_accept <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_prdata  <= w_rdata;
                        r_pslverr <= w_err;
                        r_accept  <= w_accept;
                        r_pready  <= 1'b1;
                        r_state   <= RESP;
                    end
                end
                RESP: begin
                    r_pready <= 1'b0;
                    r_accept <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_pready <= 1'b0;
                    r_accept <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    // Configuration registers, written only on the commit edge of RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src <= '0;
            r_dst <= '0;
            r_len <= '0;
        end else if (w_commit) begin
            if (r_word == REG_SRC_ADDR[11:2]) r_src <= r_wdata;
            if (r_word == REG_DST_ADDR[11:2]) r_dst <= r_wdata;
            if (r_word == REG_BYTE_LEN[11:2]) r_len <= r_wdata[15:0];
        end
    end

    // Engine handshake: start pulse, busy tracking and the sticky done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= w_startCommit;
            if (w_startCommit) begin
                r_busy <= 1'b1;
            end else if (done_i && r_busy) begin
                r_busy <= 1'b0;
            end
            if (w_doneSet) begin
                r_done <= 1'b1;
            end else if (w_clearCommit) begin
                r_done <= 1'b0;
            end
        end
    end

    assign apb.pready_o  = r_pready;
    assign apb.prdata_o  = r_prdata;
    assign apb.pslverr_o = r_pslverr;
    assign src_addr_o    = r_src;
    assign dst_addr_o    = r_dst;
    assign byte_len_o    = r_len;
    assign start_o       = r_start;

endmodule

// File: tb/tb_dmac_apb_slave.sv
// Directed scoreboard bench for the DMAC APB configuration slave.
module tb_dmac_apb_slave;

    logic        clk;
    logic        rst_n;
    logic        done_i;
    logic [31:0] src_addr_o;
    logic [31:0] dst_addr_o;
    logic [15:0] byte_len_o;
    logic        start_o;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } resp_t;

    resp_t sb[$];

    dmac_apb_slave_if apb();

    dmac_apb_slave #(.VERSION(32'h0001_2024)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .apb        (apb),
        .src_addr_o (src_addr_o),
        .dst_addr_o (dst_addr_o),
        .byte_len_o (byte_len_o),
        .start_o    (start_o),
        .done_i     (done_i)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: whenever the slave signals pready, pop and compare the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && apb.pready_o) begin
            checkCount++;
            if (sb.size() == 0) begin
                errorCount++;
                $display("[TB] FAIL unexpectedPready: got pready=1 required no response");
            end else begin
                resp_t e;
                e = sb.pop_front();
                if (apb.prdata_o !== e.rdata || apb.pslverr_o !== e.err) begin
                    errorCount++;
                    $display("[TB] FAIL %s: got prdata=%h pslverr=%b required prdata=%h pslverr=%b",
                             e.name, apb.prdata_o, apb.pslverr_o, e.rdata, e.err);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    // One full APB transfer; the expected response goes to the scoreboard.
    task automatic applyStimulus(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input string name);
        int waited;
        resp_t e;
        e.rdata = expRdata;
        e.err   = expErr;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk); #1;
        apb.psel_i    = 1'b1;
        apb.penable_i = 1'b0;
        apb.paddr_i   = addr;
        apb.pwrite_i  = wr;
        apb.pwdata_i  = wdata;
        @(posedge clk); #1;
        apb.penable_i = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!apb.pready_o && waited < 4) begin
            waited++;
            @(negedge clk);
        end
        checkOutput({name, "_latency"}, 32'(waited), 32'd1);
        if (!apb.pready_o && sb.size() > 0) void'(sb.pop_back());
        @(posedge clk); #1;
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = 1'b0;
    endtask

    task automatic pulseDone();
        @(posedge clk); #1;
        done_i = 1'b1;
        @(posedge clk); #1;
        done_i = 1'b0;
    endtask

    initial begin
        logic seen;
        resp_t e;
        rst_n         = 1'b0;
        done_i        = 1'b0;
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
        apb.paddr_i   = '0;
        apb.pwrite_i  = 1'b0;
        apb.pwdata_i  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        checkOutput("rstPready",  {31'd0, apb.pready_o},  32'd0);
        checkOutput("rstPrdata",  apb.prdata_o,           32'd0);
        checkOutput("rstPslverr", {31'd0, apb.pslverr_o}, 32'd0);
        checkOutput("rstSrc",     src_addr_o,             32'd0);
        checkOutput("rstDst",     dst_addr_o,             32'd0);
        checkOutput("rstLen",     {16'd0, byte_len_o},    32'd0);
        checkOutput("rstStart",   {31'd0, start_o},       32'd0);

        applyStimulus(12'h000, 1'b0, 32'h0, 32'h0001_2024, 1'b0, "readVersion");

        applyStimulus(12'h100, 1'b1, 32'h1000_0000, 32'h0, 1'b0, "writeSrc");
        applyStimulus(12'h104, 1'b1, 32'h2000_0000, 32'h0, 1'b0, "writeDst");
        applyStimulus(12'h108, 1'b1, 32'h0000_0040, 32'h0, 1'b0, "writeLen");
        checkOutput("srcOut", src_addr_o,          32'h1000_0000);
        checkOutput("dstOut", dst_addr_o,          32'h2000_0000);
        checkOutput("lenOut", {16'd0, byte_len_o}, 32'h0000_0040);
        applyStimulus(12'h100, 1'b0, 32'h0, 32'h1000_0000, 1'b0, "readSrc");
        applyStimulus(12'h104, 1'b0, 32'h0, 32'h2000_0000, 1'b0, "readDst");
        applyStimulus(12'h108, 1'b0, 32'h0, 32'h0000_0040, 1'b0, "readLen");
        applyStimulus(12'h10B, 1'b1, 32'hFFFF_0080, 32'h0, 1'b0, "writeLenWide");
        applyStimulus(12'h108, 1'b0, 32'h0, 32'h0000_0080, 1'b0, "readLenMasked");
        checkOutput("lenOutMasked", {16'd0, byte_len_o}, 32'h0000_0080);

        applyStimulus(12'h10C, 1'b1, 32'h1, 32'h0, 1'b0, "cmdStart");
        checkOutput("startPulse", {31'd0, start_o}, 32'd1);
        @(posedge clk); #1;
        checkOutput("startOneCycle", {31'd0, start_o}, 32'd0);
        applyStimulus(12'h110, 1'b0, 32'h0, 32'h1, 1'b0, "statusBusy");
        applyStimulus(12'h100, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b1, "writeSrcBusy");
        applyStimulus(12'h10C, 1'b1, 32'h3, 32'h0, 1'b1, "cmdStartClearBusy");
        checkOutput("noRestart", {31'd0, start_o}, 32'd0);
        applyStimulus(12'h100, 1'b0, 32'h0, 32'h1000_0000, 1'b0, "readSrcUnchanged");

        pulseDone();
        applyStimulus(12'h110, 1'b0, 32'h0, 32'h2, 1'b0, "statusDone");
        applyStimulus(12'h10C, 1'b1, 32'h2, 32'h0, 1'b0, "cmdClear");
        applyStimulus(12'h110, 1'b0, 32'h0, 32'h0, 1'b0, "statusCleared");
        pulseDone();
        applyStimulus(12'h110, 1'b0, 32'h0, 32'h0, 1'b0, "statusIdleDone");

        applyStimulus(12'h200, 1'b0, 32'h0, 32'h0, 1'b1, "readUnmapped");
        applyStimulus(12'h110, 1'b1, 32'h3, 32'h0, 1'b1, "writeStatusRO");
        applyStimulus(12'h000, 1'b1, 32'h5, 32'h0, 1'b1, "writeVersionRO");
        applyStimulus(12'h10C, 1'b0, 32'h0, 32'h0, 1'b0, "readCmdZero");

        // Drop psel while the slave is in WAIT: nothing may complete or commit.
        @(posedge clk); #1;
        apb.psel_i    = 1'b1;
        apb.penable_i = 1'b0;
        apb.paddr_i   = 12'h100;
        apb.pwrite_i  = 1'b1;
        apb.pwdata_i  = 32'h5555_5555;
        @(posedge clk); #1;
        apb.psel_i    = 1'b0;
        apb.pwrite_i  = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | apb.pready_o;
        end
        checkOutput("dropNoPready", {31'd0, seen}, 32'd0);
        checkOutput("dropNoCommit", src_addr_o, 32'h1000_0000);

        // Reset during RESP of a CMD start write: the start must never be seen.
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.name  = "cmdBeforeReset";
        sb.push_back(e);
        @(posedge clk); #1;
        apb.psel_i    = 1'b1;
        apb.penable_i = 1'b0;
        apb.paddr_i   = 12'h10C;
        apb.pwrite_i  = 1'b1;
        apb.pwdata_i  = 32'h1;
        @(posedge clk); #1;
        apb.penable_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | start_o;
        end
        checkOutput("resetNoStart", {31'd0, seen}, 32'd0);
        checkOutput("resetPready",  {31'd0, apb.pready_o}, 32'd0);
        apb.psel_i    = 1'b0;
        apb.penable_i = 1'b0;
        apb.pwrite_i  = 1'b0;
        rst_n = 1'b1;
        applyStimulus(12'h110, 1'b0, 32'h0, 32'h0, 1'b0, "statusAfterReset");
        checkOutput("srcAfterReset", src_addr_o, 32'd0);
        checkOutput("startAfterReset", {31'd0, start_o}, 32'd0);

        repeat (2) @(posedge clk);
        checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
